// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU load/store and host debug accesses onto one
// single-port synchronous data RAM. Reads take 3 cycles to ack, writes 2.
// Optional build macro MEM_ARB_RR_EN selects a round-robin tie-break;
// without it the CPU always wins simultaneous requests.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU load/store path
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_get,
    input  logic                  cpu_set,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    // host debug bus
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_read,
    input  logic                  host_write,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_ack,
    // data RAM port
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_en,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    // status
    output logic                  busy,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    // One candidate access as presented to the RAM.
    typedef struct packed {
        logic                  host;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } grant_t;

    state_t                st_q, st_d;
    logic                  own_host_q, own_host_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_d;
    logic                  ram_en_d, ram_we_d;
    logic                  cpu_ack_d, host_ack_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_d, host_rdata_d;

    logic                  cpu_req, host_req, any_req, pick_host;
    grant_t                cpu_gnt, host_gnt, gnt;

    // A requester acked this cycle is still holding its old request; mask it.
    // Asserting set alongside get makes the access a write.
    assign cpu_req  = (cpu_get | cpu_set) & ~cpu_ack;
    assign host_req = (host_read | host_write) & ~host_ack;
    assign any_req  = cpu_req | host_req;

    assign cpu_gnt  = '{host: 1'b0, wr: cpu_set, addr: cpu_addr[ADDR_WIDTH-1:0],
                        wdata: cpu_wdata};
    assign host_gnt = '{host: 1'b1, wr: host_write, addr: host_addr,
                        wdata: host_wdata};

    // Upper CPU address bits are outside the RAM and deliberately ignored.
    generate
        if (DATA_WIDTH > ADDR_WIDTH) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^cpu_addr[DATA_WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

`ifdef MEM_ARB_RR_EN
    logic last_host_q;

    // On a tie the requester that did not win the previous grant goes first.
    assign pick_host = host_req & (~cpu_req | ~last_host_q);

    // Track the last winner; reset to host so the CPU takes the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            last_host_q <= 1'b1;
        else if (st_q == IDLE && any_req)
            last_host_q <= pick_host;
    end
`else
    // Fixed priority: the host only wins when the CPU is not asking.
    assign pick_host = host_req & ~cpu_req;
`endif

    assign gnt = pick_host ? host_gnt : cpu_gnt;

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        st_d         = st_q;
        own_host_d   = own_host_q;
        op_wr_d      = op_wr_q;
        ram_addr_d   = ram_addr;
        ram_wdata_d  = ram_wdata;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata;
        host_rdata_d = host_rdata;

        case (st_q)
            IDLE: begin
                if (any_req) begin
                    own_host_d  = gnt.host;
                    op_wr_d     = gnt.wr;
                    ram_addr_d  = gnt.addr;
                    ram_wdata_d = gnt.wdata;
                    ram_en_d    = 1'b1;
                    ram_we_d    = gnt.wr;
                    st_d        = ACCESS;
                end
            end
            ACCESS: begin
                // RAM samples en/we this cycle; a write is done after it.
                if (op_wr_q) begin
                    cpu_ack_d  = ~own_host_q;
                    host_ack_d = own_host_q;
                    st_d       = IDLE;
                end else begin
                    st_d = RDWAIT;
                end
            end
            RDWAIT: begin
                // Read data is valid now; only the owner's copy is updated.
                if (own_host_q)
                    host_rdata_d = ram_rdata;
                else
                    cpu_rdata_d = ram_rdata;
                cpu_ack_d  = ~own_host_q;
                host_ack_d = own_host_q;
                st_d       = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= IDLE;
            own_host_q <= 1'b0;
            op_wr_q    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            st_q       <= st_d;
            own_host_q <= own_host_d;
            op_wr_q    <= op_wr_d;
            ram_addr   <= ram_addr_d;
            ram_wdata  <= ram_wdata_d;
            ram_en     <= ram_en_d;
            ram_we     <= ram_we_d;
            cpu_ack    <= cpu_ack_d;
            host_ack   <= host_ack_d;
            cpu_rdata  <= cpu_rdata_d;
            host_rdata <= host_rdata_d;
        end
    end

    assign busy  = (st_q != IDLE);
    assign state = st_q;

    // Invariants: acks are exclusive single-cycle pulses; RAM enable only in ACCESS.
    a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
        !(cpu_ack && host_ack));
    a_cpu_ack_pulse: assert property (@(posedge clk) disable iff (reset)
        cpu_ack |=> !cpu_ack);
    a_host_ack_pulse: assert property (@(posedge clk) disable iff (reset)
        host_ack |=> !host_ack);
    a_en_in_access: assert property (@(posedge clk) disable iff (reset)
        ram_en |-> (st_q == ACCESS));
    a_we_needs_en: assert property (@(posedge clk) disable iff (reset)
        ram_we |-> ram_en);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with a scoreboard of expected acks.
module tb_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] cpu_addr = '0, cpu_wdata = '0;
    logic          cpu_get = 1'b0, cpu_set = 1'b0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_read = 1'b0, host_write = 1'b0;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_en, ram_we;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;
    logic [1:0]    state;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_get(cpu_get),
        .cpu_set(cpu_set), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_read(host_read),
        .host_write(host_write), .host_rdata(host_rdata), .host_ack(host_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en),
        .ram_we(ram_we), .ram_rdata(ram_rdata),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        bit            host;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input bit host, input bit rd, input logic [DW-1:0] data);
        exp_t e;
        e.host = host; e.rd = rd; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic check_pop(input bit who, input logic [DW-1:0] rdata);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_ack: got ack from %0s, want none", who ? "host" : "cpu");
        end else begin
            e = sbq.pop_front();
            if (e.host != who) begin
                bad++;
                $display("FAIL sb_order: got ack from %0s want %0s",
                         who ? "host" : "cpu", e.host ? "host" : "cpu");
            end else if (e.rd && rdata !== e.data) begin
                bad++;
                $display("FAIL sb_rdata_%0s: got %0h want %0h", who ? "host" : "cpu", rdata, e.data);
            end
        end
    endtask

    // Monitor: every ack pops the scoreboard and is compared there.
    always @(negedge clk) begin
        if (!reset && (cpu_ack || host_ack)) begin
            chk("ack_onehot", {31'b0, cpu_ack & host_ack}, 32'd0);
            if (cpu_ack)  check_pop(1'b0, cpu_rdata);
            if (host_ack) check_pop(1'b1, host_rdata);
        end
    end

    // One access from an idle arbiter; call at posedge+1, returns at posedge+1.
    task automatic op(input bit host, input bit wr, input bit rd,
                      input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [DW-1:0] exp_rd, input int exp_lat, input string nm);
        int lat;
        bit done;
        push_exp(host, rd & ~wr, exp_rd);
        if (host) begin
            host_addr = addr[AW-1:0]; host_wdata = wd; host_write = wr; host_read = rd;
        end else begin
            cpu_addr = addr; cpu_wdata = wd; cpu_set = wr; cpu_get = rd;
        end
        lat = 0; done = 0;
        while (!done && lat < 12) begin
            @(negedge clk);
            if (lat == 1) begin
                chk({nm, "_en"},   {31'b0, ram_en}, 32'd1);
                chk({nm, "_we"},   {31'b0, ram_we}, {31'b0, wr});
                chk({nm, "_addr"}, {24'b0, ram_addr}, {24'b0, addr[AW-1:0]});
                chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
                if (wr) chk({nm, "_wdata"}, {16'b0, ram_wdata}, {16'b0, wd});
            end
            if (host ? host_ack : cpu_ack) done = 1;
            else lat++;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        if (wr) chk({nm, "_idle_at_ack"}, {30'b0, state}, 32'd0);
        host_write = 0; host_read = 0; cpu_set = 0; cpu_get = 0;
        @(posedge clk); #1;
    endtask

    // CPU read of 0x05 and host read of 0x20 raised together.
    task automatic tie(input bit host_first, input string nm);
        int cyc, cl, hl;
        if (host_first) begin
            push_exp(1, 1, 16'h1234); push_exp(0, 1, 16'hBEEF);
        end else begin
            push_exp(0, 1, 16'hBEEF); push_exp(1, 1, 16'h1234);
        end
        cpu_addr = 16'h0005; cpu_get = 1;
        host_addr = 8'h20;   host_read = 1;
        cyc = 0; cl = -1; hl = -1;
        while ((cl < 0 || hl < 0) && cyc < 20) begin
            @(negedge clk);
            if (cpu_ack)  begin cl = cyc; cpu_get = 0; end
            if (host_ack) begin hl = cyc; host_read = 0; end
            cyc++;
        end
        chk({nm, "_cpu_lat"},  cl, host_first ? 32'd6 : 32'd3);
        chk({nm, "_host_lat"}, hl, host_first ? 32'd3 : 32'd6);
        cpu_get = 0; host_read = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Idle after reset: everything quiet.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
            chk("rst_state", {30'b0, state}, 32'd0);
            if (i == 0) begin
                chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_acks", {30'b0, cpu_ack, host_ack}, 32'd0);
                chk("rst_rdata", {cpu_rdata, host_rdata}, 32'd0);
                chk("rst_ram_bus", {8'b0, ram_addr, ram_wdata}, 32'd0);
            end
        end
        @(posedge clk); #1;

        // CPU write then read back; upper address bits are dropped.
        op(0, 1, 0, 16'h0105, 16'hBEEF, 16'h0000, 2, "cpu_wr");
        op(0, 0, 1, 16'h0005, 16'h0000, 16'hBEEF, 3, "cpu_rd");
        chk("cpu_rdata_held", {16'b0, cpu_rdata}, 32'h0000BEEF);

        // Host write then read; CPU side untouched.
        op(1, 1, 0, 16'h0020, 16'h1234, 16'h0000, 2, "host_wr");
        op(1, 0, 1, 16'h0020, 16'h0000, 16'h1234, 3, "host_rd");
        chk("host_rdata_held", {16'b0, host_rdata}, 32'h00001234);
        chk("cpu_rdata_kept", {16'b0, cpu_rdata}, 32'h0000BEEF);

        // First tie: CPU first in either build.
        tie(0, "tie1");
        // CPU write makes CPU the last winner, then tie again.
        op(0, 1, 0, 16'h0030, 16'h5A5A, 16'h0000, 2, "cpu_wr30");
`ifdef MEM_ARB_RR_EN
        tie(1, "tie2");
`else
        tie(0, "tie2");
`endif

        // get and set together is a write.
        op(0, 1, 1, 16'h0010, 16'h00AA, 16'h0000, 2, "cpu_rw");
        chk("mem_10", {16'b0, mem[8'h10]}, 32'h000000AA);
        op(1, 0, 1, 16'h0010, 16'h0000, 16'h00AA, 3, "host_rd10");

        // Reset in the RDWAIT cycle of a host read aborts it.
        host_addr = 8'h20; host_read = 1;
        @(negedge clk); chk("abort_n0_state", {30'b0, state}, 32'd0);
        @(negedge clk); chk("abort_n1_state", {30'b0, state}, 32'd1);
        @(negedge clk); chk("abort_n2_state", {30'b0, state}, 32'd2);
        reset = 1;
        @(negedge clk);
        chk("abort_no_ack", {31'b0, host_ack}, 32'd0);
        chk("abort_rdata", {16'b0, host_rdata}, 32'd0);
        chk("abort_ram_en", {31'b0, ram_en}, 32'd0);
        chk("abort_state", {30'b0, state}, 32'd0);
        reset = 0; host_read = 0;
        @(posedge clk); #1;
        op(1, 0, 1, 16'h0020, 16'h0000, 16'h1234, 3, "host_rd_again");

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port synchronous data RAM between the CPU load/store path (`memaddr`/`memval`/`memget`/`memset`) and the external debug/host bus. It serialises accesses, returns read data and a one-cycle acknowledge per requester, and lets the CPU control FSM stall on `cpu_ack` while the host inspects or patches data memory. It sits between `cpu` and the data RAM in the top level.

## Interface
- `DATA_WIDTH`, 16: RAM word width (matches `WORD_SIZE`).
- `ADDR_WIDTH`, 8: RAM address width; requester addresses are truncated to the low `ADDR_WIDTH` bits.
- `clk` in 1: the single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_addr` in DATA_WIDTH: CPU word address.
- `cpu_wdata` in DATA_WIDTH: CPU store data.
- `cpu_get` in 1: CPU read request (level, held until `cpu_ack`).
- `cpu_set` in 1: CPU write request (level, held until `cpu_ack`).
- `cpu_rdata` out DATA_WIDTH: last CPU read result, held until the next CPU read completes.
- `cpu_ack` out 1: one-cycle completion pulse for the CPU.
- `host_addr` in ADDR_WIDTH: host word address.
- `host_wdata` in DATA_WIDTH: host write data.
- `host_read`, `host_write` in 1: host requests (level, held until `host_ack`).
- `host_rdata` out DATA_WIDTH: last host read result, held.
- `host_ack` out 1: one-cycle completion pulse for the host.
- `ram_addr` out ADDR_WIDTH, `ram_wdata` out DATA_WIDTH, `ram_en` out 1, `ram_we` out 1: registered RAM controls.
- `ram_rdata` in DATA_WIDTH: RAM read data, valid the cycle after the `ram_en` cycle.
- `busy` out 1: high in any state other than IDLE.
- `state` out 2: FSM state (debug): IDLE=0, ACCESS=1, RDWAIT=2.

## Operation
- Request classification: `get|set` for CPU, `read|write` for host. If both read and write are high from one requester, it is treated as a write.
- A requester whose `ack` is high in the current cycle is ignored in IDLE, so a held request is never re-granted.
- IDLE: if any eligible request exists, select a winner, register `ram_addr`, `ram_wdata`, `ram_en`=1, and `ram_we`=write, record the owner and operation, and go to ACCESS. Otherwise stay in IDLE with `ram_en`=`ram_we`=0.
- ACCESS (`ram_en` visible to RAM):
  - Write: clear `ram_en`/`ram_we`, register the owner's `ack`=1, go to IDLE.
  - Read: clear `ram_en`, go to RDWAIT.
- RDWAIT: capture `ram_rdata` into the owner's `rdata`, register the owner's `ack`=1, go to IDLE.
- `ack` is a single-cycle pulse. Only one of `cpu_ack`/`host_ack` is high in any cycle.
- A non-owner's `rdata` is never modified.
- A request arriving while the arbiter is busy waits and is considered in the next IDLE cycle. It is never dropped.
- Reset: state=IDLE; `ram_en`=`ram_we`=0; `cpu_ack`=`host_ack`=0; `cpu_rdata`=`host_rdata`=0; `ram_addr`=`ram_wdata`=0; `busy`=0; the last-winner pointer is set to host, so the CPU wins the first tie.
- Reset mid-operation aborts the access: no ack is issued, and `ram_en`/`ram_we` are low in the cycle after reset.

## Timing
- The request is first seen high in cycle N, with the arbiter in IDLE and the requester eligible.
- Cycle N+1: `ram_en` high (and `ram_we` high for a write), `busy`=1.
- Write: `ack` high in cycle N+2, with the arbiter already back in IDLE.
- Read: `ram_rdata` valid in cycle N+2. `rdata` is updated and `ack` is high in cycle N+3.
- The requester must deassert its request in the `ack` cycle, or re-assert it for a new access one or more cycles later.
- Back-to-back throughput: one write per 2 cycles, one read per 3 cycles.
- A grant in the cycle immediately after an ack goes only to the other requester, or to none.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break. On simultaneous eligible requests, the requester that did not win the previous grant wins; the last-winner pointer updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, CPU always wins ties; the pointer logic is absent.
- Host starvation is possible only in the undefined build, and only under continuous CPU traffic.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, `state`=0, and no `ram_en`.
- CPU `cpu_set` at `cpu_addr`=0x0105 with `cpu_wdata`=0xBEEF -> `ram_addr`=0x05, `ram_we`=1 in N+1, `cpu_ack` in N+2. A following `cpu_get` at 0x0005 -> `cpu_rdata`=0xBEEF with `cpu_ack` in N+3.
- Host write 0x1234 to 0x20, then host read of 0x20 -> `host_rdata`=0x1234. Throughout, `cpu_rdata` is unchanged and `cpu_ack` never pulses.
- CPU read and host read asserted in the same cycle, both held:
  - `MEM_ARB_RR_EN` defined: CPU acks first, host second; a repeat tie then goes host first.
  - `MEM_ARB_RR_EN` undefined: CPU always first.
- `cpu_get`=`cpu_set`=1 at 0x10 with data 0x00AA -> treated as a write: `ram_we`=1, `cpu_ack` in N+2, RAM[0x10]=0x00AA.
- `reset` asserted in the RDWAIT cycle of a host read -> no `host_ack`, `host_rdata`=0, `ram_en`=0 next cycle. The re-issued read completes normally.
